// File: rtl/tone_player_pkg.sv
// -----------------------------------------------------------------------------
// tone_player_pkg
// Shared types and constants for the tone player and its ms prescaler.
//   state_t         : player FSM states (ST_GAP only reachable when
//                     TONE_PLAYER_GAP_EN is defined)
//   DEFAULT_HALF_W  : default width of the half-period field (clock cycles)
//   DEFAULT_DUR_W   : default width of the duration field (ms)
//   TICK_W          : width of ticks_per_milli and of the ms prescaler
//   REST            : half-period value that means "silence"
// -----------------------------------------------------------------------------
package tone_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_HALF_W = 16;
    localparam int DEFAULT_DUR_W  = 12;
    localparam int TICK_W         = 16;
    localparam int REST           = 0;

endpackage

// File: rtl/tone_player_ms_prescaler.sv
// -----------------------------------------------------------------------------
// ms_prescaler
// Divides the clock down to a one-cycle ms_tick every max(ticks_per_milli,1)
// enabled cycles. Shared by every ms-timed block.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   clear            : synchronous clear of the count (wins over enable)
//   enable           : count while high
//   ticks_per_milli  : cycles per ms, 0 treated as 1; sampled every cycle
//   ms_tick          : combinational, high on the terminal count while enabled
// -----------------------------------------------------------------------------
module ms_prescaler
    import tone_player_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [TICK_W-1:0] ticks_per_milli,
    output logic              ms_tick
);

    logic [TICK_W-1:0] count;
    logic [TICK_W-1:0] last;

    // Terminal count is max(T,1)-1. Using >= means a T lowered below the
    // current count ends the ms immediately instead of running to wrap.
    always_comb begin
        last = '0;
        if (ticks_per_milli != '0) begin
            last = ticks_per_milli - 1'b1;
        end
    end

    assign ms_tick = enable && (count >= last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (ms_tick) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_player.sv
// -----------------------------------------------------------------------------
// tone_player
// Plays one note command at a time as a square wave on `sound`.
// Optional feature macro: TONE_PLAYER_GAP_EN adds a GAP_MS-long silent gap
// after every note (state ST_GAP).
// Handshake: a command transfers on a rising clk edge where note_valid and
// note_ready are both high; note_ready is (state == ST_IDLE), combinational
// from the state register; note_valid may stay high while note_ready is low
// and the command is simply held off; fields are latched on transfer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ticks_per_milli   : cycles per ms (0 treated as 1)
//   note_valid/ready  : command handshake
//   note_half_period  : cycles per half-wave, 0 = rest
//   note_dur_ms       : note length in ms (0 = one PLAY cycle)
//   sound             : registered speaker drive
//   busy              : high in PLAY or GAP
//   note_done         : registered one-cycle pulse after the last PLAY cycle
// -----------------------------------------------------------------------------
module tone_player
    import tone_player_pkg::*;
#(
    parameter int HALF_W = DEFAULT_HALF_W,
    parameter int DUR_W  = DEFAULT_DUR_W,
    parameter int GAP_MS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TICK_W-1:0] ticks_per_milli,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [HALF_W-1:0] note_half_period,
    input  logic [DUR_W-1:0]  note_dur_ms,
    output logic              sound,
    output logic              busy,
    output logic              note_done
);

    state_t            state;
    logic [HALF_W-1:0] half_r;
    logic [HALF_W-1:0] tone_cnt;
    logic [DUR_W-1:0]  dur_cnt;

    logic ms_tick;
    logic accept;
    logic play_end;

`ifdef TONE_PLAYER_GAP_EN
    logic [31:0] gap_cnt;
    logic        gap_end;
`endif

    assign note_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign accept     = note_valid && note_ready;

    // The note ends on the tick that consumes its last ms, or straight away
    // when loaded with 0 ms; dur_cnt therefore never decrements past 1.
    assign play_end = (state == ST_PLAY) &&
                      ((dur_cnt == '0) || (ms_tick && (dur_cnt == DUR_W'(1))));

`ifdef TONE_PLAYER_GAP_EN
    assign gap_end = (state == ST_GAP) &&
                     ((gap_cnt == '0) || (ms_tick && (gap_cnt == 32'd1)));
`endif

    // Prescaler restarts at every accept and at the PLAY->GAP hand-over.
    ms_prescaler u_ms_prescaler (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (accept || play_end),
        .enable          (busy),
        .ticks_per_milli (ticks_per_milli),
        .ms_tick         (ms_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            half_r    <= '0;
            tone_cnt  <= '0;
            dur_cnt   <= '0;
            sound     <= 1'b0;
            note_done <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            note_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        half_r   <= note_half_period;
                        dur_cnt  <= note_dur_ms;
                        tone_cnt <= '0;
                        sound    <= 1'b0;
                        state    <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (play_end) begin
                        sound     <= 1'b0;
                        note_done <= 1'b1;
                        tone_cnt  <= '0;
`ifdef TONE_PLAYER_GAP_EN
                        gap_cnt   <= 32'(GAP_MS);
                        state     <= ST_GAP;
`else
                        state     <= ST_IDLE;
`endif
                    end else begin
                        if (ms_tick) begin
                            dur_cnt <= dur_cnt - 1'b1;
                        end
                        if (half_r == HALF_W'(REST)) begin
                            sound    <= 1'b0;
                            tone_cnt <= '0;
                        end else if (tone_cnt >= half_r - 1'b1) begin
                            sound    <= ~sound;
                            tone_cnt <= '0;
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end
                    end
                end

`ifdef TONE_PLAYER_GAP_EN
                ST_GAP: begin
                    sound <= 1'b0;
                    if (gap_end) begin
                        state <= ST_IDLE;
                    end else if (ms_tick) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// -----------------------------------------------------------------------------
// tb_tone_player
// Bench for tone_player. Each accepted note pushes its expected
// {accept-to-done cycles, number of sound rises} onto exp_q; a negedge
// monitor measures every note and pops/compares on note_done.
// -----------------------------------------------------------------------------
module tb_tone_player;

    localparam int HALF_W = 16;
    localparam int DUR_W  = 12;
    localparam int GAP_MS = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       ticks_per_milli = 16'd100;
    logic              note_valid = 1'b0;
    logic              note_ready;
    logic [HALF_W-1:0] note_half_period = '0;
    logic [DUR_W-1:0]  note_dur_ms = '0;
    logic              sound;
    logic              busy;
    logic              note_done;

    logic [47:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    tone_player #(
        .HALF_W (HALF_W),
        .DUR_W  (DUR_W),
        .GAP_MS (GAP_MS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ticks_per_milli  (ticks_per_milli),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_half_period (note_half_period),
        .note_dur_ms      (note_dur_ms),
        .sound            (sound),
        .busy             (busy),
        .note_done        (note_done)
    );

    // ---------------- reference model ----------------
    // PLAY length is D*max(T,1) (1 for D=0); done is seen one cycle later.
    // Toggles land H, 2H, ... cycles after accept; the final PLAY edge forces
    // 0 instead, so rises are the odd multiples of H up to play-1.
    function automatic logic [47:0] model(input int h, input int d, input int t);
        int teff;
        int play;
        int r;
        teff = (t == 0) ? 1 : t;
        play = (d == 0) ? 1 : d * teff;
        r    = (h == 0) ? 0 : (((play - 1) / h) + 1) / 2;
        return {32'(play + 1), 16'(r)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic tracking   = 1'b0;
    logic acc_next   = 1'b0;
    logic prev_sound = 1'b0;
    logic prev_done  = 1'b0;
    int   cyc        = 0;
    int   rises      = 0;

    always @(negedge clk) begin
        logic [47:0] e;
        if (!rst_n) begin
            tracking   = 1'b0;
            acc_next   = 1'b0;
            prev_sound = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (acc_next) begin
                tracking   = 1'b1;
                cyc        = 0;
                rises      = 0;
                prev_sound = 1'b0;
                acc_next   = 1'b0;
            end
            if (tracking) begin
                cyc++;
                if (sound && !prev_sound) rises++;
                prev_sound = sound;
            end
            vectors++;
            if (sound && !busy) begin
                errors++;
                $display("FAIL idle_silent: sound=%0b while busy=%0b at %0t", sound, busy, $time);
            end
            if (note_done) begin
                vectors++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: note_done high two cycles in a row at %0t", $time);
                end
                if (exp_q.size() == 0 || !tracking) begin
                    errors++;
                    $display("FAIL unexpected_done: note_done=1 with no note pending at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    vectors += 2;
                    if (32'(cyc) !== e[47:16]) begin
                        errors++;
                        $display("FAIL done_latency: got %0d cycles, expected %0d", cyc, e[47:16]);
                    end
                    if (16'(rises) !== e[15:0]) begin
                        errors++;
                        $display("FAIL sound_rises: got %0d, expected %0d", rises, e[15:0]);
                    end
                end
                tracking = 1'b0;
            end
            prev_done = note_done;
            if (note_valid && note_ready) acc_next = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    // Offers a note and returns at accept edge + #1. waited = cycles spent.
    task automatic send_note(input int h, input int d, input int t,
                             input bit expect_done, input bit hold,
                             output int waited);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        ticks_per_milli  = 16'(t);
        note_half_period = HALF_W'(h);
        note_dur_ms      = DUR_W'(d);
        note_valid       = 1'b1;
        if (expect_done) exp_q.push_back(model(h, d, t));
        while (!acc && n < 5000) begin
            acc = note_ready;
            @(posedge clk);
            #1;
            n++;
        end
        waited = n;
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: note_ready=%0b, expected 1 within 5000 cycles", note_ready);
        end
        if (!hold) begin
            // Scramble the fields to show the latched copy is used.
            note_valid       = 1'b0;
            note_half_period = HALF_W'($urandom);
            note_dur_ms      = DUR_W'($urandom);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d notes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int w;
        #1;
        vectors += 4;
        if (sound !== 1'b0)      begin errors++; $display("FAIL por_sound: got %b expected 0", sound); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL por_busy: got %b expected 0", busy); end
        if (note_done !== 1'b0)  begin errors++; $display("FAIL por_done: got %b expected 0", note_done); end
        if (note_ready !== 1'b1) begin errors++; $display("FAIL por_ready: got %b expected 1", note_ready); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors += 2;
        if (note_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b expected 1", note_ready); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rel_busy: got %b expected 0", busy); end

        // Abort a tone while sound is high.
        send_note(50, 5, 100, 1'b0, 1'b0, w);
        repeat (60) @(posedge clk);
        #1;
        vectors++;
        if (sound !== 1'b1) begin errors++; $display("FAIL pre_abort_sound: got %b expected 1", sound); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 4;
        if (sound !== 1'b0)      begin errors++; $display("FAIL abort_sound: got %b expected 0", sound); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (note_done !== 1'b0)  begin errors++; $display("FAIL abort_done: got %b expected 0", note_done); end
        if (note_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", note_ready); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (note_ready !== 1'b1) begin errors++; $display("FAIL abort_rel_ready: got %b expected 1", note_ready); end
        // Any note_done from the aborted note is caught by the monitor.
        repeat (600) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_note();
        int w;
        int k;
        send_note(50, 3, 100, 1'b1, 1'b0, w);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
        k = 0;
        while (!sound && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (k != 50) begin errors++; $display("FAIL first_rise: got %0d cycles, expected 50", k); end
        wait_done(1000);
    endtask

    task automatic test_rest_and_zero();
        int w;
        send_note(0, 2, 100, 1'b1, 1'b0, w);
        wait_done(1000);
        send_note(37, 0, 100, 1'b1, 1'b0, w);
        wait_done(100);
    endtask

    task automatic test_edge_cases();
        int w;
        send_note(1, 4, 0, 1'b1, 1'b0, w);
        wait_done(100);
        send_note(1, 3, 5, 1'b1, 1'b0, w);
        wait_done(100);
        send_note(65535, 1, 3, 1'b1, 1'b0, w);
        wait_done(100);
        for (int i = 0; i < 6; i++) begin
            send_note(int'($urandom_range(0, 20)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 12)), 1'b1, 1'b0, w);
            wait_done(200);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int exp_w;
        send_note(7, 2, 20, 1'b1, 1'b1, w);
        send_note(9, 3, 20, 1'b1, 1'b1, w);
`ifdef TONE_PLAYER_GAP_EN
        exp_w = 40 + 1 + GAP_MS * 20;
`else
        exp_w = 40 + 1;
`endif
        vectors++;
        if (w != exp_w) begin errors++; $display("FAIL b2b_turnaround: waited %0d cycles, expected %0d", w, exp_w); end
        send_note(4, 1, 20, 1'b1, 1'b0, w);
        wait_done(2000);
    endtask

    task automatic test_gap();
        int w;
        int n;
        int k;
        send_note(5, 1, 100, 1'b1, 1'b0, w);
        n = 0;
        while (!note_done && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (!note_done) begin errors++; $display("FAIL gap_done_timeout: note_done=%b expected 1", note_done); end
`ifdef TONE_PLAYER_GAP_EN
        k = 0;
        while (!note_ready && k < 2000) begin
            vectors += 2;
            if (sound !== 1'b0) begin errors++; $display("FAIL gap_sound: got %b expected 0", sound); end
            if (busy !== 1'b1)  begin errors++; $display("FAIL gap_busy: got %b expected 1", busy); end
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (k != GAP_MS * 100) begin errors++; $display("FAIL gap_length: got %0d cycles, expected %0d", k, GAP_MS * 100); end
`else
        k = 0;
        vectors += 2;
        if (note_ready !== 1'b1) begin errors++; $display("FAIL done_ready: got %b expected 1", note_ready); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
`endif
        wait_done(100);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic_note();
        test_rest_and_zero();
        test_edge_cases();
        test_back_to_back();
        test_gap();
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: %0d notes pending, expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tone_player.md
# tone_player

Downstream audio stage that turns note commands into the square-wave speaker drive on `uio_out[0]`. The music sequencer hands it one note at a time over a valid/ready handshake: a half-period in clock cycles, or a rest, plus a duration in milliseconds. The player produces the tone for exactly that duration and then signals completion. Millisecond timing comes from the same `ticks_per_milli` value the top level already distributes.

## Interface
Parameters:
- `HALF_W`, 16: width of the note half-period field, in clock cycles.
- `DUR_W`, 12: width of the duration field, in ms.
- `GAP_MS`, 10: length of the articulation gap in ms (used only when `TONE_PLAYER_GAP_EN` is defined).

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ticks_per_milli` input 16: clock cycles per ms; 0 is treated as 1.
- `note_valid` input 1: a note command is offered.
- `note_ready` output 1: the player can accept a command.
- `note_half_period` input HALF_W: cycles per half-wave; 0 means rest (silence).
- `note_dur_ms` input DUR_W: note length in ms.
- `sound` output 1: speaker drive.
- `busy` output 1: high in PLAY or GAP.
- `note_done` output 1: one-cycle pulse when a note finishes.

## Operation
- States: IDLE, PLAY, and GAP (GAP exists only with the macro).
- Handshake:
  - `note_ready` = (state == IDLE). It is combinational from the state register.
  - A command is accepted on a rising edge where `note_valid && note_ready`.
  - Fields are latched at acceptance. Input changes after acceptance are ignored.
  - `note_valid` may be held high with no ready; nothing happens and nothing is lost.
- On accept, the following are cleared: the tone counter, the ms prescaler, and `sound` (forced 0). The duration counter loads `note_dur_ms`. Next state is PLAY.
- PLAY, tone generation:
  - The tone counter increments every cycle.
  - When it reaches `half_period-1`, `sound` toggles and the counter clears.
  - With `half_period == 1`, `sound` toggles every cycle.
  - With `half_period == 0` (rest), `sound` is held 0.
- PLAY, duration:
  - The ms prescaler counts 0..max(T,1)-1 and emits `ms_tick` on the terminal count. T = `ticks_per_milli`, sampled every cycle.
  - The duration counter decrements on each `ms_tick`.
  - When it reaches 0, the note ends.
  - `note_dur_ms == 0` ends the note after exactly 1 PLAY cycle.
- End of note:
  - `sound` is forced to 0 on the same edge.
  - `note_done` is registered high for the following cycle.
  - State goes to GAP (macro defined) or IDLE.
- GAP: silent for `GAP_MS` ms, counted with the same prescaler, which is cleared on entry. Then IDLE.
- Reset mid-operation: all state clears asynchronously. `sound` drops immediately. No `note_done` is issued for the aborted note.
- Arithmetic:
  - All counters are unsigned and never wrap.
  - The tone counter is HALF_W bits wide, the duration counter DUR_W bits, the prescaler 16 bits.

## Timing
- Reset values:
  - state IDLE.
  - `sound` 0, `note_done` 0, `busy` 0.
  - `note_ready` 1 once `rst_n` is deasserted (it is 1 during reset too, since the state is IDLE).
- Accept at edge E:
  - `busy` is high from E+1.
  - The first `sound` rise happens at edge E+H, where H = half_period.
- PLAY lasts exactly D·T cycles for D ≥ 1, and 1 cycle for D = 0.
- `note_done` and (without the macro) `note_ready` both go high in the cycle after the last PLAY cycle. A back-to-back note can be accepted on that same edge. The completion-to-accept turnaround is zero cycles.
- With the macro, `note_ready` rises GAP_MS·T cycles after `note_done`.
- A change to `ticks_per_milli` mid-note takes effect at the next prescaler comparison. If the new value is below the current count, the prescaler terminates at once.

## Configuration
- The macro is `TONE_PLAYER_GAP_EN`.
- Defined: GAP state is present. Every note, rests included, is followed by `GAP_MS` ms of silence during which `note_ready` = 0 and `busy` = 1.
- Undefined: the GAP state and its logic are not compiled. The player returns to IDLE directly and the `GAP_MS` parameter is unused.

## Structure
- Package `tone_player_pkg` holds:
  - the state enum (IDLE, PLAY, GAP);
  - default widths `HALF_W` and `DUR_W`;
  - the `REST` constant (half_period 0).
- Sub-module `ms_prescaler` takes clk, rst_n, a synchronous clear, an enable, and `ticks_per_milli`, and outputs `ms_tick`. It is shared with other ms-timed blocks in the design.

## Test plan
- Reset check: reset asserted mid-tone, T=100, H=50, D=5 → `sound`=0 immediately, `busy`=0, no `note_done`, `note_ready`=1 after release.
- Basic note: T=100, H=50, D=3 → 300 PLAY cycles, `sound` period 100 cycles, first rise 50 cycles after accept, single `note_done` pulse at cycle 301.
- Rest and zero-duration commands:
  - H=0, D=2 → `sound` stays 0 for 200 cycles, then `note_done`.
  - D=0 → `note_done` 2 cycles after accept.
- Back-to-back notes (macro off): `note_valid` held high with two queued notes → second accepted on the `note_done` cycle, no idle gap, `sound` continuous except the forced 0.
- Gap (macro on, GAP_MS=10, T=100): after `note_done`, `note_ready` stays 0 for 1000 cycles and `sound`=0 throughout.
- Edge cases: T=0 with D=4 → note lasts 4 cycles. H=1 → `sound` toggles every cycle.
